// File: rtl/tl_pkg.sv
// Shared TileLink A-channel definitions: opcode constants, field widths and the
// packed A-channel beat used by the fragmenter and its output register.
package tl_pkg;

    localparam int OPCODE_W = 3;
    localparam int PARAM_W  = 3;
    localparam int SIZE_W   = 3;
    localparam int SOURCE_W = 6;
    localparam int ADDR_W   = 33;
    localparam int MASK_W   = 8;

    typedef enum logic [OPCODE_W-1:0] {
        PUT_FULL    = 3'd0,
        PUT_PARTIAL = 3'd1,
        GET         = 3'd4,
        HINT        = 3'd5
    } a_opcode_e;

    // Opcode is carried as raw bits: the fragmenter never interprets it.
    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [PARAM_W-1:0]  param;
        logic [SIZE_W-1:0]   size;
        logic [SOURCE_W-1:0] source;
        logic [ADDR_W-1:0]   address;
        logic [MASK_W-1:0]   mask;
    } a_chan_t;

endpackage

// File: rtl/tl_a_out_reg.sv
// One-entry valid/ready pipeline register over an A-channel beat plus a sideband.
// Accepts a new beat whenever it is empty or being drained in the same cycle.
module tl_a_out_reg
    import tl_pkg::*;
#(
    parameter int SB_W = 3
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  a_chan_t         in_bits,
    input  logic [SB_W-1:0] in_sb,
    input  logic            out_ready,
    output logic            out_valid,
    output a_chan_t         out_bits,
    output logic [SB_W-1:0] out_sb
);

    logic            valid_reg;
    a_chan_t         bits_reg;
    logic [SB_W-1:0] sb_reg;
    logic            fire;

    assign in_ready = ~valid_reg | out_ready;
    assign fire     = in_valid & in_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_reg <= 1'b0;
            bits_reg  <= '0;
            sb_reg    <= '0;
        end else if (fire) begin
            valid_reg <= 1'b1;
            bits_reg  <= in_bits;
            sb_reg    <= in_sb;
        end else if (out_ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign out_valid = valid_reg;
    assign out_bits  = bits_reg;
    assign out_sb    = sb_reg;

endmodule

// File: rtl/tl_a_fragmenter.sv
// Address-only A-channel fragmenter: splits each request into aligned single-beat
// fragments and holds the upstream repeater via in_repeat until the last one fires.
module tl_a_fragmenter
    import tl_pkg::*;
#(
    parameter int LOG_FRAG = 3,
    parameter int LOG_MAX  = 6,
    parameter int CNT_W    = 3
) (
    input  logic                clock,
    input  logic                reset,
    output logic                in_ready,
    input  logic                in_valid,
    input  logic [OPCODE_W-1:0] in_bits_opcode,
    input  logic [PARAM_W-1:0]  in_bits_param,
    input  logic [SIZE_W-1:0]   in_bits_size,
    input  logic [SOURCE_W-1:0] in_bits_source,
    input  logic [ADDR_W-1:0]   in_bits_address,
    input  logic [MASK_W-1:0]   in_bits_mask,
    output logic                in_repeat,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [OPCODE_W-1:0] out_bits_opcode,
    output logic [PARAM_W-1:0]  out_bits_param,
    output logic [SIZE_W-1:0]   out_bits_size,
    output logic [SOURCE_W-1:0] out_bits_source,
    output logic [ADDR_W-1:0]   out_bits_address,
    output logic [MASK_W-1:0]   out_bits_mask,
    output logic [CNT_W-1:0]    out_frag_remaining,
    output logic                err_size
);

    localparam logic [SIZE_W-1:0] LOG_FRAG_S = SIZE_W'(LOG_FRAG);
    localparam logic [SIZE_W-1:0] LOG_MAX_S  = SIZE_W'(LOG_MAX);

    logic              oversize;
    logic [SIZE_W-1:0] eff_size;
    logic [SIZE_W-1:0] shamt;
    logic [CNT_W:0]    nfrag;
    logic [CNT_W-1:0]  last_idx;
    logic [CNT_W-1:0]  rem;
    logic [CNT_W-1:0]  frag_cnt_reg;
    logic [CNT_W-1:0]  frag_cnt_next;
    logic              err_size_reg;
    logic              fire;
    a_chan_t           frag;
    a_chan_t           out_chan;

    assign oversize = in_bits_size > LOG_MAX_S;
    assign eff_size = oversize ? LOG_MAX_S : in_bits_size;
    assign shamt    = (eff_size > LOG_FRAG_S) ? (eff_size - LOG_FRAG_S) : '0;
    assign nfrag    = (CNT_W+1)'(1) << shamt;
    assign last_idx = CNT_W'(nfrag - (CNT_W+1)'(1));
    assign rem      = last_idx - frag_cnt_reg;

    assign in_repeat = (rem != '0);
    assign fire      = in_valid & in_ready;

    // Aligned input means OR-ing in the beat offset never needs a carry.
    always_comb begin
        frag         = '0;
        frag.opcode  = in_bits_opcode;
        frag.param   = in_bits_param;
        frag.size    = (eff_size > LOG_FRAG_S) ? LOG_FRAG_S : eff_size;
        frag.source  = in_bits_source;
        frag.address = in_bits_address | (ADDR_W'(frag_cnt_reg) << LOG_FRAG);
        frag.mask    = (nfrag == (CNT_W+1)'(1)) ? in_bits_mask : '1;
    end

    assign frag_cnt_next = (rem == '0) ? '0 : frag_cnt_reg + CNT_W'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frag_cnt_reg <= '0;
            err_size_reg <= 1'b0;
        end else if (fire) begin
            frag_cnt_reg <= frag_cnt_next;
            if (oversize) begin
                err_size_reg <= 1'b1;
            end
        end
    end

    tl_a_out_reg #(
        .SB_W(CNT_W)
    ) u_out_reg (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_bits  (frag),
        .in_sb    (rem),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_bits (out_chan),
        .out_sb   (out_frag_remaining)
    );

    assign out_bits_opcode  = out_chan.opcode;
    assign out_bits_param   = out_chan.param;
    assign out_bits_size    = out_chan.size;
    assign out_bits_source  = out_chan.source;
    assign out_bits_address = out_chan.address;
    assign out_bits_mask    = out_chan.mask;
    assign err_size         = err_size_reg;

endmodule

// File: tb/tb_tl_a_fragmenter.sv
// Directed bench for tl_a_fragmenter: a request-level fragment model feeds a
// queue that one compare process checks against every accepted output beat.
module tb_tl_a_fragmenter;

    typedef struct packed {
        logic [2:0]  op;
        logic [2:0]  param;
        logic [2:0]  size;
        logic [5:0]  src;
        logic [32:0] addr;
        logic [7:0]  mask;
        logic [2:0]  rem;
    } frag_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_ready;
    logic        in_valid;
    logic [2:0]  in_bits_opcode, in_bits_param, in_bits_size;
    logic [5:0]  in_bits_source;
    logic [32:0] in_bits_address;
    logic [7:0]  in_bits_mask;
    logic        in_repeat;
    logic        out_ready;
    logic        out_valid;
    logic [2:0]  out_bits_opcode, out_bits_param, out_bits_size;
    logic [5:0]  out_bits_source;
    logic [32:0] out_bits_address;
    logic [7:0]  out_bits_mask;
    logic [2:0]  out_frag_remaining;
    logic        err_size;

    tl_a_fragmenter dut (
        .clock             (clock),
        .reset             (reset),
        .in_ready          (in_ready),
        .in_valid          (in_valid),
        .in_bits_opcode    (in_bits_opcode),
        .in_bits_param     (in_bits_param),
        .in_bits_size      (in_bits_size),
        .in_bits_source    (in_bits_source),
        .in_bits_address   (in_bits_address),
        .in_bits_mask      (in_bits_mask),
        .in_repeat         (in_repeat),
        .out_ready         (out_ready),
        .out_valid         (out_valid),
        .out_bits_opcode   (out_bits_opcode),
        .out_bits_param    (out_bits_param),
        .out_bits_size     (out_bits_size),
        .out_bits_source   (out_bits_source),
        .out_bits_address  (out_bits_address),
        .out_bits_mask     (out_bits_mask),
        .out_frag_remaining(out_frag_remaining),
        .err_size          (err_size)
    );

    always #5 clock = ~clock;

    frag_t exp_q[$];
    frag_t got_q[$];
    int    got_cyc[$];
    int    n_chk = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    ready_mode = 0;
    int    rcnt = 0;
    logic  exp_err = 1'b0;
    logic  err_pend = 1'b0;
    logic  stall_prev = 1'b0;
    frag_t stall_bits;

    function automatic frag_t cur_out();
        frag_t f;
        f.op    = out_bits_opcode;
        f.param = out_bits_param;
        f.size  = out_bits_size;
        f.src   = out_bits_source;
        f.addr  = out_bits_address;
        f.mask  = out_bits_mask;
        f.rem   = out_frag_remaining;
        return f;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Request-level model: a request of 2^size bytes becomes 8-byte beats.
    task automatic model(input logic [2:0] op, input logic [2:0] param, input logic [2:0] size,
                         input logic [5:0] src, input logic [32:0] addr, input logic [7:0] mask,
                         output int n);
        int eff;
        frag_t f;
        eff = (int'(size) > 6) ? 6 : int'(size);
        n   = (eff <= 3) ? 1 : (1 << (eff - 3));
        for (int k = 0; k < n; k++) begin
            f.op    = op;
            f.param = param;
            f.size  = (eff > 3) ? 3'd3 : size;
            f.src   = src;
            f.addr  = addr + 33'(k * 8);
            f.mask  = (n == 1) ? mask : 8'hFF;
            f.rem   = 3'(n - 1 - k);
            exp_q.push_back(f);
        end
    endtask

    always @(negedge clock) begin
        frag_t c, e;
        #2;
        cyc++;
        if (reset) begin
            check("err_size", 64'(err_size), 64'(exp_err));
            exp_err  = exp_err | err_pend;
            err_pend = 1'b0;
            c = cur_out();
            if (stall_prev) begin
                check("stall_valid", 64'(out_valid), 64'(1));
                check("stall_hold", 64'(c), 64'(stall_bits));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frag", 64'(c.addr), 64'(0));
                    if (c.addr == 0) check("unexpected_frag_valid", 64'(out_valid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("frag", 64'(c), 64'(e));
                    got_q.push_back(c);
                    got_cyc.push_back(cyc);
                    $display("frag op=%0d size=%0d src=0x%0h addr=0x%0h mask=0x%0h rem=%0d",
                             c.op, c.size, c.src, c.addr, c.mask, c.rem);
                end
            end
            stall_prev = out_valid && !out_ready;
            stall_bits = c;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Drive one request until all its fragments fire; entered and left at a negedge.
    task automatic send(input logic [2:0] op, input logic [2:0] size, input logic [5:0] src,
                        input logic [32:0] addr, input logic [7:0] mask, input int stop_after);
        int n, fires, guard, lim;
        model(op, 3'd0, size, src, addr, mask, n);
        lim = (stop_after > 0) ? stop_after : n;
        in_bits_opcode  = op;
        in_bits_param   = 3'd0;
        in_bits_size    = size;
        in_bits_source  = src;
        in_bits_address = addr;
        in_bits_mask    = mask;
        in_valid        = 1'b1;
        fires = 0;
        guard = 0;
        while (fires < lim && guard < 100) begin
            out_ready = (ready_mode == 0) ? 1'b1 : ((rcnt % 3) == 0);
            rcnt++;
            #1;
            if (in_ready) begin
                check("in_repeat", 64'(in_repeat), 64'(fires != n - 1));
                if (size > 3'd6) err_pend = 1'b1;
                fires++;
            end
            @(negedge clock);
            guard++;
        end
        check("fire_count", 64'(fires), 64'(lim));
        check("latency_valid", 64'(out_valid), 64'(1));
    endtask

    task automatic drain();
        int g;
        in_valid = 1'b0;
        g = 0;
        while (exp_q.size() > 0 && g < 100) begin
            out_ready = 1'b1;
            @(negedge clock);
            g++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'(0));
        check("drain_idle", 64'(out_valid), 64'(0));
    endtask

    initial begin
        int b;
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_bits_opcode = '0; in_bits_param = '0; in_bits_size = '0;
        in_bits_source = '0; in_bits_address = '0; in_bits_mask = '0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_err_size", 64'(err_size), 64'(0));
        check("rst_out_bits", 64'(cur_out()), 64'(0));
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Single-beat Get keeps its own size and mask.
        send(3'd4, 3'd3, 6'h11, 33'h1_0000_0040, 8'h0F, 0);
        drain();
        check("t1_addr", 64'(got_q[0].addr), 64'h1_0000_0040);
        check("t1_mask", 64'(got_q[0].mask), 64'h0F);
        check("t1_rem", 64'(got_q[0].rem), 64'd0);

        // 64-byte Get at full throughput.
        send(3'd4, 3'd6, 6'h05, 33'h0_0000_1000, 8'h0F, 0);
        drain();
        check("t2_first_addr", 64'(got_q[1].addr), 64'h1000);
        check("t2_first_rem", 64'(got_q[1].rem), 64'd7);
        check("t2_last_addr", 64'(got_q[8].addr), 64'h1038);
        check("t2_last_rem", 64'(got_q[8].rem), 64'd0);
        check("t2_last_mask", 64'(got_q[8].mask), 64'hFF);
        check("t2_no_bubble", 64'(got_cyc[8] - got_cyc[1]), 64'd7);

        // Same request under a 1,0,0 downstream ready pattern.
        ready_mode = 1;
        rcnt = 0;
        send(3'd4, 3'd6, 6'h06, 33'h0_0000_2000, 8'hFF, 0);
        drain();
        ready_mode = 0;
        check("t3_count", 64'(got_q.size()), 64'd17);

        // Oversize Hint is fragmented as 64 bytes and latches err_size.
        send(3'd5, 3'd7, 6'h07, 33'h0_0000_3000, 8'hFF, 0);
        drain();
        check("t4_err", 64'(err_size), 64'd1);
        check("t4_last_addr", 64'(got_q[got_q.size()-1].addr), 64'h3038);
        send(3'd4, 3'd2, 6'h08, 33'h0_0000_3104, 8'h0F, 0);
        drain();
        check("t4_err_sticky", 64'(err_size), 64'd1);
        check("t4_small_size", 64'(got_q[got_q.size()-1].size), 64'd2);

        // Back-to-back 16-byte requests.
        send(3'd4, 3'd4, 6'h09, 33'h0_0000_4000, 8'hFF, 0);
        send(3'd4, 3'd4, 6'h0A, 33'h0_0000_4010, 8'hFF, 0);
        drain();
        b = got_q.size();
        check("t6_no_bubble", 64'(got_cyc[b-1] - got_cyc[b-4]), 64'd3);
        check("t6_second_base", 64'(got_q[b-2].addr), 64'h4010);

        // Reset after the third fragment of a 32-byte request.
        send(3'd4, 3'd5, 6'h0B, 33'h0_0000_5000, 8'hFF, 3);
        #1 reset = 1'b0;
        #1;
        check("t5_rst_valid", 64'(out_valid), 64'd0);
        check("t5_rst_err", 64'(err_size), 64'd0);
        exp_q.delete();
        exp_err = 1'b0;
        err_pend = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        send(3'd4, 3'd4, 6'h0C, 33'h0_0000_6000, 8'h3C, 0);
        drain();
        b = got_q.size();
        check("t5_new_base", 64'(got_q[b-2].addr), 64'h6000);
        check("t5_new_rem", 64'(got_q[b-2].rem), 64'd1);
        check("t5_new_last", 64'(got_q[b-1].addr), 64'h6008);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
